ram_1p_arb: RTL and testbench
=============================

# ram_1p_arb

Two-requester round-robin arbiter that shares one single-port SRAM macro (32x512 in the default build) between two bus hosts, e.g. instruction fetch and data port. It sits directly in front of the RAM primitive and drives its req/write/addr/wdata/wmask inputs. It issues grants in the same cycle as the request. It tracks which requester owns each in-flight access so that read data and a response pulse are routed back to the correct host. It also keeps a saturating contention counter for performance monitoring.

## Interface
- Width, 32, data width in bits
- Depth, 512, RAM words; Aw = $clog2(Depth) derived
- CntW, 16, width of contention counter
- clk_i  in  1  clock; all state changes on its rising edge
- rst_i  in  1  asynchronous, active-high reset
- req_i  in  2  per-requester access request (index 0, 1)
- write_i  in  2  per-requester write enable
- addr_i  in  2×Aw  per-requester word address
- wdata_i  in  2×Width  per-requester write data
- wmask_i  in  2×Width  per-requester bit write mask
- gnt_o  out  2  grant, one-hot or zero, combinational from req_i and state
- rvalid_o  out  2  response pulse for a previously granted access
- rdata_o  out  Width  read data, shared, qualified by rvalid_o
- ram_req_o  out  1  to RAM req_i
- ram_write_o  out  1  to RAM write_i
- ram_addr_o  out  Aw  to RAM addr_i
- ram_wdata_o  out  Width  to RAM wdata_i
- ram_wmask_o  out  Width  to RAM wmask_i
- ram_rdata_i  in  Width  from RAM rdata_o, valid one cycle after ram_req_o
- conflict_cnt_o  out  CntW  count of cycles with both req_i bits high

## Operation
- Arbitration:
  - Single requester high: granted immediately.
  - Both high: grant goes to the index not equal to last_q.
  - No request: gnt_o = 0 and ram_req_o = 0.
- last_q (1 bit) is updated to the granted index on every grant, contended or not.
- RAM drive:
  - ram_req_o = |gnt_o.
  - ram_write_o, ram_addr_o, ram_wdata_o and ram_wmask_o are muxed from the granted requester.
  - When idle, the mux selects requester 0. Its values are don't-care, but must not be X-propagating.
- Response tracking:
  - On each grant, owner index and valid are registered.
  - Next cycle, rvalid_o[owner] = 1 and rdata_o = ram_rdata_i.
  - Writes also produce an rvalid_o pulse. rdata_o is unspecified for writes.
- An ungranted requester keeps req_i and payload stable until granted. The block does not check this.
- Back-to-back grants are allowed every cycle. Throughput is one access per cycle.
- conflict_cnt_o increments by 1 on every cycle where req_i == 2'b11. It saturates at all-ones and does not wrap.

## Timing
- Reset values: last_q = 1, so requester 0 wins the first contention. Response valid = 0, rvalid_o = 0, conflict_cnt_o = 0, rdata_o = 0.
- gnt_o and ram_* outputs are combinational. There are 0 cycles from req_i to ram_req_o.
- Read latency from grant to rvalid_o is 1 cycle, or 2 with the macro below.
- Simultaneous events:
  - A grant in cycle N and a response for the grant from cycle N-1 coexist. The pipeline handles one issue and one return per cycle.
  - Both requesters high in every cycle gives strict alternation 0,1,0,1.
- Reset mid-operation: in-flight responses are dropped, with no rvalid_o after rst_i deasserts. The counter clears and last_q returns to 1.

## Configuration
- RAM_ARB_RDATA_REG_EN, when defined:
  - Adds a register stage on ram_rdata_i and the owner/valid tracking.
  - rvalid_o and rdata_o appear 2 cycles after the grant.
  - Both stages reset to 0, and a mid-operation reset drops both.
- Undefined: 1-cycle latency with rdata_o driven combinationally from ram_rdata_i through the owner mux.

## Test plan
- Reset, then req_i = 2'b01, write_i = 0, addr 9'h005 -> gnt_o = 01, ram_addr_o = 5; next cycle rvalid_o = 01, rdata_o = ram_rdata_i.
- req_i = 2'b11 held 4 cycles after reset -> gnt_o sequence 01, 10, 01, 10; conflict_cnt_o = 4; rvalid_o follows the same sequence 1 cycle later.
- Requester 1 writes wdata 32'hDEADBEEF, wmask all-ones to addr 9'h1FF -> ram_write_o = 1, ram_wdata_o = DEADBEEF; rvalid_o = 10 next cycle.
- Force conflict_cnt_o near saturation with CntW = 2 and both requesting for 6 cycles -> counter reaches 3 and holds 3.
- Assert rst_i the cycle after a grant -> no rvalid_o pulse after reset release; gnt_o follows req_i with requester 0 winning the first contention.
- With RAM_ARB_RDATA_REG_EN, issue back-to-back reads 0 then 1 -> rvalid_o = 01 at cycle +2, then 10 at +3, each with matching rdata.

Source files
------------

// File: rtl/ram_1p_arb.sv
// ram_1p_arb: round-robin front end that shares one single-port SRAM between two hosts.
// Define RAM_ARB_RDATA_REG_EN to register read data and response tracking (2-cycle latency).
module ram_1p_arb #(
  parameter int Width = 32,
  parameter int Depth = 512,
  parameter int CntW  = 16,
  localparam int Aw   = $clog2(Depth)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [1:0]         req_i,
  input  logic [1:0]         write_i,
  input  logic [2*Aw-1:0]    addr_i,
  input  logic [2*Width-1:0] wdata_i,
  input  logic [2*Width-1:0] wmask_i,
  output logic [1:0]         gnt_o,
  output logic [1:0]         rvalid_o,
  output logic [Width-1:0]   rdata_o,
  output logic               ram_req_o,
  output logic               ram_write_o,
  output logic [Aw-1:0]      ram_addr_o,
  output logic [Width-1:0]   ram_wdata_o,
  output logic [Width-1:0]   ram_wmask_o,
  input  logic [Width-1:0]   ram_rdata_i,
  output logic [CntW-1:0]    conflict_cnt_o
);

  logic [1:0]      gnt_s;
  logic            sel_s;
  logic            last_q, last_d;
  logic            valid_q, valid_d;
  logic            owner_q, owner_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Grant selection; on contention the requester not served last wins
  always_comb begin
    gnt_s = 2'b00;
    sel_s = 1'b0;
    case (req_i)
      2'b01: begin gnt_s = 2'b01; sel_s = 1'b0; end
      2'b10: begin gnt_s = 2'b10; sel_s = 1'b1; end
      2'b11: begin
        if (last_q) begin
          gnt_s = 2'b01; sel_s = 1'b0;
        end else begin
          gnt_s = 2'b10; sel_s = 1'b1;
        end
      end
      default: begin gnt_s = 2'b00; sel_s = 1'b0; end
    endcase
  end

  // RAM payload mux; idle cycles present requester 0
  always_comb begin
    ram_req_o = |gnt_s;
    if (sel_s) begin
      ram_write_o = write_i[1];
      ram_addr_o  = addr_i[2*Aw-1:Aw];
      ram_wdata_o = wdata_i[2*Width-1:Width];
      ram_wmask_o = wmask_i[2*Width-1:Width];
    end else begin
      ram_write_o = write_i[0];
      ram_addr_o  = addr_i[Aw-1:0];
      ram_wdata_o = wdata_i[Width-1:0];
      ram_wmask_o = wmask_i[Width-1:0];
    end
  end

  // Arbitration history, response ownership and saturating contention count
  always_comb begin
    valid_d = |gnt_s;
    owner_d = sel_s;
    if (|gnt_s) begin
      last_d = sel_s;
    end else begin
      last_d = last_q;
    end
    if ((req_i == 2'b11) && (cnt_q != {CntW{1'b1}})) begin
      cnt_d = cnt_q + CntW'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q  <= 1'b1;
      valid_q <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= {CntW{1'b0}};
    end else begin
      last_q  <= last_d;
      valid_q <= valid_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef RAM_ARB_RDATA_REG_EN
  logic             valid2_q;
  logic             owner2_q;
  logic [Width-1:0] rdata2_q, rdata2_d;

  // Capture read data only when a response is in flight
  always_comb begin
    if (valid_q) begin
      rdata2_d = ram_rdata_i;
    end else begin
      rdata2_d = rdata2_q;
    end
  end

  // Second response stage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid2_q <= 1'b0;
      owner2_q <= 1'b0;
      rdata2_q <= {Width{1'b0}};
    end else begin
      valid2_q <= valid_q;
      owner2_q <= owner_q;
      rdata2_q <= rdata2_d;
    end
  end

  // Response routing
  always_comb begin
    rvalid_o = {valid2_q & owner2_q, valid2_q & ~owner2_q};
    rdata_o  = rdata2_q;
  end
`else
  // Response routing straight from the RAM read port
  always_comb begin
    rvalid_o = {valid_q & owner_q, valid_q & ~owner_q};
    if (valid_q) begin
      rdata_o = ram_rdata_i;
    end else begin
      rdata_o = {Width{1'b0}};
    end
  end
`endif

  assign gnt_o          = gnt_s;
  assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_ram_1p_arb.sv
// Testbench for ram_1p_arb: directed vector table, reset sequence and randomized traffic
// checked against a queue-based response model.
module tb_ram_1p_arb;
  localparam int W  = 32;
  localparam int AW = 9;
`ifdef RAM_ARB_RDATA_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam logic [W-1:0] D0   = 32'h0000_1111;
  localparam logic [W-1:0] ONES = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [1:0]    req_i, write_i;
  logic [2*AW-1:0] addr_i;
  logic [2*W-1:0]  wdata_i, wmask_i;
  logic [1:0]    gnt_o, rvalid_o;
  logic [W-1:0]  rdata_o;
  logic          ram_req_o, ram_write_o;
  logic [AW-1:0] ram_addr_o;
  logic [W-1:0]  ram_wdata_o, ram_wmask_o, ram_rdata_i;
  logic [15:0]   conflict_cnt_o;

  logic [1:0]    s_gnt, s_rvalid;
  logic [W-1:0]  s_rdata, s_wdata, s_wmask;
  logic          s_req, s_write;
  logic [AW-1:0] s_addr;
  logic [1:0]    s_cnt;

  always #5 clk = ~clk;

  ram_1p_arb #(.Width(32), .Depth(512), .CntW(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .write_i(write_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .wmask_i(wmask_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .ram_req_o(ram_req_o), .ram_write_o(ram_write_o),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_wmask_o(ram_wmask_o),
    .ram_rdata_i(ram_rdata_i), .conflict_cnt_o(conflict_cnt_o));

  ram_1p_arb #(.Width(32), .Depth(512), .CntW(2)) dut_sat (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .write_i(write_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .wmask_i(wmask_i), .gnt_o(s_gnt), .rvalid_o(s_rvalid),
    .rdata_o(s_rdata), .ram_req_o(s_req), .ram_write_o(s_write),
    .ram_addr_o(s_addr), .ram_wdata_o(s_wdata), .ram_wmask_o(s_wmask),
    .ram_rdata_i(ram_rdata_i), .conflict_cnt_o(s_cnt));

  int checks = 0;
  int errors = 0;

  typedef struct {
    int  due;
    int  g;
    bit  owner;
    bit  wr;
  } resp_t;

  resp_t        pend[$];
  logic [W-1:0] rd_hist [0:4095];
  int           last_win;
  int           conflicts;
  int           cyc;
  int           cur_win;
  logic [1:0]   cur_eg, cur_req, cur_wr, model_gnt;

  typedef struct {
    logic [1:0]    req;
    logic [1:0]    wr;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [W-1:0]  d1;
    logic [1:0]    egnt;
    logic [AW-1:0] eaddr;
    logic          ewr;
    logic [W-1:0]  ewdata;
    int            ecnt;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    last_win  = 1;
    conflicts = 0;
  endtask

  // Drive one cycle of inputs and compare everything visible in that cycle.
  task automatic apply(input logic [1:0] req, input logic [1:0] wr,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic [W-1:0] m0, input logic [W-1:0] m1);
    logic [1:0] erv;
    int sel;
    req_i = req; write_i = wr; addr_i = {a1, a0};
    wdata_i = {d1, d0}; wmask_i = {m1, m0};
    ram_rdata_i = $urandom();
    rd_hist[cyc] = ram_rdata_i;
    cur_req = req; cur_wr = wr;
    if (req == 2'b11) cur_win = (last_win == 0) ? 1 : 0;
    else if (req == 2'b01) cur_win = 0;
    else if (req == 2'b10) cur_win = 1;
    else cur_win = -1;
    cur_eg = (cur_win < 0) ? 2'b00 : ((cur_win == 0) ? 2'b01 : 2'b10);
    sel = (cur_win == 1) ? 1 : 0;
    @(negedge clk);
    check("gnt", gnt_o, cur_eg);
    check("ram_req", ram_req_o, cur_win >= 0);
    check("ram_write", ram_write_o, wr[sel]);
    check("ram_addr", ram_addr_o, (sel == 1) ? a1 : a0);
    check("ram_wdata", ram_wdata_o, (sel == 1) ? d1 : d0);
    check("ram_wmask", ram_wmask_o, (sel == 1) ? m1 : m0);
    erv = 2'b00;
    if (pend.size() > 0 && pend[0].due == cyc) erv = pend[0].owner ? 2'b10 : 2'b01;
    check("rvalid", rvalid_o, erv);
    if (erv != 2'b00 && !pend[0].wr) check("rdata", rdata_o, rd_hist[pend[0].g + 1]);
    check("conflict_cnt", conflict_cnt_o, (conflicts > 65535) ? 65535 : conflicts);
    check("conflict_sat", s_cnt, (conflicts > 3) ? 3 : conflicts);
  endtask

  task automatic advance();
    resp_t r;
    @(posedge clk); #1;
    if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
    if (cur_win >= 0) begin
      r.due = cyc + LAT; r.g = cyc; r.owner = (cur_win == 1); r.wr = cur_wr[cur_win];
      pend.push_back(r);
      last_win = cur_win;
    end
    if (cur_req == 2'b11) conflicts++;
    model_gnt = cur_eg;
    cyc++;
  endtask

  task automatic step(input logic [1:0] req, input logic [1:0] wr,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [W-1:0] d0, input logic [W-1:0] d1,
                      input logic [W-1:0] m0, input logic [W-1:0] m1);
    apply(req, wr, a0, a1, d0, d1, m0, m1);
    advance();
  endtask

  logic [1:0]    hreq, hwr;
  logic [AW-1:0] ha [2];
  logic [W-1:0]  hd [2];
  logic [W-1:0]  hm [2];

  initial begin
    tbl[0] = '{2'b11, 2'b00, 9'h00A, 9'h014, 32'h2222_2222, 2'b01, 9'h00A, 1'b0, D0, 0};
    tbl[1] = '{2'b11, 2'b00, 9'h00A, 9'h014, 32'h2222_2222, 2'b10, 9'h014, 1'b0, 32'h2222_2222, 1};
    tbl[2] = '{2'b11, 2'b00, 9'h00B, 9'h014, 32'h2222_2222, 2'b01, 9'h00B, 1'b0, D0, 2};
    tbl[3] = '{2'b11, 2'b00, 9'h00B, 9'h015, 32'h3333_3333, 2'b10, 9'h015, 1'b0, 32'h3333_3333, 3};
    tbl[4] = '{2'b01, 2'b00, 9'h005, 9'h000, 32'h0000_0000, 2'b01, 9'h005, 1'b0, D0, 4};
    tbl[5] = '{2'b10, 2'b10, 9'h000, 9'h1FF, 32'hDEAD_BEEF, 2'b10, 9'h1FF, 1'b1, 32'hDEAD_BEEF, 4};
    tbl[6] = '{2'b00, 2'b00, 9'h007, 9'h000, 32'h0000_0000, 2'b00, 9'h007, 1'b0, D0, 4};
    tbl[7] = '{2'b10, 2'b00, 9'h000, 9'h033, 32'h0000_0000, 2'b10, 9'h033, 1'b0, 32'h0000_0000, 4};
    tbl[8] = '{2'b11, 2'b01, 9'h044, 9'h055, 32'h0000_0000, 2'b01, 9'h044, 1'b1, D0, 4};
    tbl[9] = '{2'b11, 2'b00, 9'h046, 9'h055, 32'h0000_0000, 2'b10, 9'h055, 1'b0, 32'h0000_0000, 5};

    rst_i = 1'b1; req_i = 2'b00; write_i = 2'b00; addr_i = '0;
    wdata_i = '0; wmask_i = '0; ram_rdata_i = 32'h0;
    cyc = 0; model_gnt = 2'b00; cur_win = -1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rvalid", rvalid_o, 2'b00);
    check("reset_rdata", rdata_o, 32'h0);
    check("reset_cnt", conflict_cnt_o, 16'h0);
    check("reset_gnt", gnt_o, 2'b00);
    check("reset_ram_req", ram_req_o, 1'b0);
    @(posedge clk); #1;
    rst_i = 1'b0;

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].req, tbl[i].wr, tbl[i].a0, tbl[i].a1, D0, tbl[i].d1, ONES, ONES);
      check("tbl_gnt", gnt_o, tbl[i].egnt);
      check("tbl_addr", ram_addr_o, tbl[i].eaddr);
      check("tbl_write", ram_write_o, tbl[i].ewr);
      check("tbl_wdata", ram_wdata_o, tbl[i].ewdata);
      check("tbl_cnt", conflict_cnt_o, tbl[i].ecnt);
      advance();
    end

    // Reset the cycle after a grant: the in-flight response must vanish
    step(2'b01, 2'b00, 9'h012, 9'h000, D0, 32'h0, ONES, ONES);
    req_i = 2'b00;
    rst_i = 1'b1;
    #1;
    check("rst_rvalid", rvalid_o, 2'b00);
    check("rst_cnt", conflict_cnt_o, 16'h0);
    check("rst_rdata", rdata_o, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_i = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) step(2'b00, 2'b00, 9'h000, 9'h000, D0, 32'h0, ONES, ONES);
    // Sustained contention after reset: alternation and counter saturation
    for (int i = 0; i < 6; i++) step(2'b11, 2'b00, AW'(i), AW'(i + 100), D0, 32'h0, ONES, ONES);
    for (int i = 0; i < 3; i++) step(2'b00, 2'b00, 9'h000, 9'h000, D0, 32'h0, ONES, ONES);

    // Randomized traffic; an ungranted requester holds its request and payload
    hreq = 2'b00; hwr = 2'b00; model_gnt = 2'b00;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!(hreq[i] && !model_gnt[i])) begin
          hreq[i] = ($urandom_range(0, 99) < 65);
          hwr[i]  = 1'($urandom_range(0, 1));
          ha[i]   = AW'($urandom());
          hd[i]   = $urandom();
          hm[i]   = $urandom();
        end
      end
      step(hreq, hwr, ha[0], ha[1], hd[0], hd[1], hm[0], hm[1]);
    end
    for (int i = 0; i < 3; i++) step(2'b00, 2'b00, 9'h000, 9'h000, D0, 32'h0, ONES, ONES);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
